sevenseg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the Nexys A7 8-digit seven-segment display.
- Shares the display between two 16-bit requesters. Source A (e.g. branch counter) goes to digits 0-3; source B (e.g. taken-branch counter) goes to digits 4-7.
- Sequences the anode scan with a programmable dwell time and an anti-ghosting blank interval.
- Snapshots both sources once per frame so a frame never shows mixed values.
- Sits in the board toplevel on the core clock, between the core's counters and the an/ca..cg pins.

---
 rtl/sevenseg_scan_ctrl.sv | 114 +++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: two 16-bit sources, per-frame snapshot.
// Optional leading-zero blanking per half when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_value_a,
  input  logic [15:0] i_value_b,
  input  logic [7:0]  i_dp,
  input  logic        i_en,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [15:0]   r_snap_a;
  logic [15:0]   r_snap_b;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame;

  logic          w_tick;
  logic          w_wrap;
  logic          w_lit;
  logic [15:0]   w_half;
  logic [15:0]   w_upper;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph;
  logic [6:0]    w_seg;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    logic [6:0] g;
    g = 7'h7F;
    unique case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_tick  = (r_cnt == CW'(DIV - 1));
  assign w_wrap  = w_tick && (r_idx == 3'd7);
  assign w_lit   = i_en && (r_cnt >= CW'(BLANK));
  assign w_half  = r_idx[2] ? r_snap_b : r_snap_a;
  assign w_upper = w_half >> {r_idx[1:0], 2'b00};
  assign w_nib   = w_upper[3:0];
  assign w_glyph = hex_decode(w_nib);

`ifdef SEVENSEG_LZB_EN
  // Blank a digit when it and every more-significant digit of its half are zero
  always_comb begin
    w_seg = w_glyph;
    if ((r_idx[1:0] != 2'd0) && (w_upper == 16'h0))
      w_seg = 7'h7F;
  end
`else
  always_comb begin
    w_seg = w_glyph;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_snap_a <= '0;
      r_snap_b <= '0;
      r_an     <= 8'hFF;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
      r_frame  <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick)
        r_idx <= r_idx + 3'd1;
      if (w_wrap) begin
        r_snap_a <= i_value_a;
        r_snap_b <= i_value_b;
      end
      r_frame <= w_wrap;
      r_an    <= w_lit ? ~(8'b1 << r_idx) : 8'hFF;
      r_seg   <= w_seg;
      r_dp    <= ~i_dp[r_idx];
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl (DIV=4, BLANK=1).
// Arithmetic reference model plus literal checks; random phase at the end.
module tb_sevenseg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FR    = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_value_a = '0;
  logic [15:0] i_value_b = '0;
  logic [7:0]  i_dp = '0;
  logic        i_en = 1'b1;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  sevenseg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst),
    .i_value_a(i_value_a), .i_value_b(i_value_b),
    .i_dp(i_dp), .i_en(i_en),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: n = clock edges since reset released
  int          n = 0;
  logic [15:0] ms_a = '0;
  logic [15:0] ms_b = '0;
  logic [7:0]  e_an = 8'hFF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fr = 1'b0;
  int          mc, md, mk, mnib;
  logic [15:0] mh;

  always @(posedge clk) begin
    if (rst) begin
      n = 0; ms_a = '0; ms_b = '0;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      mc   = n % DIV;
      md   = (n / DIV) % 8;
      mk   = md % 4;
      mh   = (md < 4) ? ms_a : ms_b;
      mnib = (int'(mh) / (16 ** mk)) % 16;
      e_an = (i_en && mc >= BLANK) ? 8'(255 - (2 ** md)) : 8'hFF;
      e_seg = glyph[mnib];
`ifdef SEVENSEG_LZB_EN
      if (mk > 0 && (int'(mh) / (16 ** mk)) == 0) e_seg = 7'h7F;
`endif
      e_dp = !i_dp[md];
      e_fr = (n % FR) == FR - 1;
      if (e_fr) begin ms_a = i_value_a; ms_b = i_value_b; end
      n = n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_an",    32'(o_an),    32'(e_an));
      chk("model_seg",   32'(o_seg),   32'(e_seg));
      chk("model_dp",    32'(o_dp),    32'(e_dp));
      chk("model_frame", 32'(o_frame), 32'(e_fr));
    end
  end

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      @(negedge clk);
      if (o_frame === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("frame_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_phase(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FR && !hit; i++) begin
      @(negedge clk);
      if (n % FR == p) hit = 1'b1;
    end
    if (!hit) chk("phase_timeout", 32'(0), 32'(1));
  endtask

  logic [7:0] an_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_tab [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};
  int nonff;
  logic [6:0] exp_blank;

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_an",    32'(o_an),    32'h FF);
    chk("rst_seg",   32'(o_seg),   32'h7F);
    chk("rst_dp",    32'(o_dp),    32'h1);
    chk("rst_frame", 32'(o_frame), 32'h0);

    i_value_a = 16'h1234;
    i_value_b = 16'hABCD;
    rst = 1'b0;
    @(negedge clk);
    chk("rel1_an", 32'(o_an), 32'hFF);
    @(negedge clk);
    chk("rel2_an",  32'(o_an),  32'hFE);
    chk("rel2_seg", 32'(o_seg), 32'h40);

    wait_frame();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("scan_blank", 32'(o_an), 32'hFF);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("scan_an",  32'(o_an),  32'(an_tab[j]));
        chk("scan_seg", 32'(o_seg), 32'(seg_tab[j]));
      end
    end
    chk("frame_period", 32'(o_frame), 32'h1);

    repeat (9) @(negedge clk);
    i_value_a = 16'h5678;
    wait_phase(14);
    chk("atomic_old_seg", 32'(o_seg), 32'h79);
    chk("atomic_old_an",  32'(o_an),  32'hF7);
    wait_frame();
    @(negedge clk);
    @(negedge clk);
    chk("atomic_new_seg", 32'(o_seg), 32'h00);

    i_en = 1'b0;
    nonff = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_an !== 8'hFF) nonff++;
    end
    chk("en_off_anodes", 32'(nonff), 32'h0);
    i_en = 1'b1;

    i_dp = 8'h01;
    wait_phase(2);
    chk("dp_digit0", 32'(o_dp), 32'h0);
    wait_phase(6);
    chk("dp_digit1", 32'(o_dp), 32'h1);
    i_dp = 8'h00;

    wait_phase(22);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an",    32'(o_an),    32'hFF);
    chk("midrst_frame", 32'(o_frame), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_an0",  32'(o_an),  32'hFE);
    chk("midrst_seg0", 32'(o_seg), 32'h40);

    i_value_a = 16'h0007;
    i_value_b = 16'h0000;
`ifdef SEVENSEG_LZB_EN
    exp_blank = 7'h7F;
`else
    exp_blank = 7'h40;
`endif
    wait_frame();
    wait_phase(2);
    chk("lzb_d0", 32'(o_seg), 32'h78);
    wait_phase(6);
    chk("lzb_d1", 32'(o_seg), 32'(exp_blank));
    wait_phase(14);
    chk("lzb_d3", 32'(o_seg), 32'(exp_blank));
    wait_phase(18);
    chk("lzb_d4", 32'(o_seg), 32'h40);
    wait_phase(22);
    chk("lzb_d5", 32'(o_seg), 32'(exp_blank));

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) i_value_a = 16'($urandom);
      if ($urandom_range(0, 39) == 0) i_value_b = 16'($urandom >> $urandom_range(0, 16));
      if ($urandom_range(0, 19) == 0) i_en = ~i_en;
      i_dp = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    i_en = 1'b1;
    repeat (4) @(negedge clk);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
